nmac_cmd_exec: RTL and testbench

- Downstream consumer of the NMAC command and sequence FIFOs filled by the management receive stage.
- Pops tagged 35-bit command words and executes NMAC establish, read and write operations on the local register bus.
- Pushes tagged response words and a response sequence record into the response FIFOs. The management transmit stage consumes those FIFOs.
- One command is executed at a time, strictly in FIFO order.

---
 rtl/nmac_pkg.sv | 43 ++++
 rtl/nmac_bus_master.sv | 88 ++++++++
 rtl/nmac_cmd_exec.sv | 234 +++++++++++++++++++++++
 tb/tb_nmac_cmd_exec.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nmac_pkg.sv
// rtl/nmac_pkg.sv - shared constants and state encoding for the NMAC command executor
//
// Purpose: tag and opcode encodings of the 35-bit NMAC command/response words,
// the executor state and body-decoding mode types, and a tag helper.
// Ports: none (package).

package nmac_pkg;

    // Word tags carried in bits [34:32] of command and response words
    localparam logic [2:0] TAG_FIRST  = 3'b001;
    localparam logic [2:0] TAG_MID    = 3'b011;
    localparam logic [2:0] TAG_LAST   = 3'b010;
    localparam logic [2:0] TAG_SINGLE = 3'b100;

    // Header opcodes in bits [31:24] of the first/single word
    localparam logic [7:0] OP_EST = 8'h01;
    localparam logic [7:0] OP_RD  = 8'h03;
    localparam logic [7:0] OP_WR  = 8'h04;

    typedef enum logic [2:0] {
        S_IDLE,   // wait for a command, its sequence record and response headroom
        S_HWAIT,  // header/sequence pop in progress
        S_HDR,    // header and sequence record valid on the FIFO outputs
        S_FETCH,  // request the next body word (stalls while the FIFO is empty)
        S_FWAIT,  // body word pop in progress
        S_WORD,   // body word valid on command_q
        S_BUS,    // register access in flight
        S_SEQ     // emit the response sequence record after the last read word
    } state_t;

    // How body words of the current command are consumed
    typedef enum logic [1:0] {
        M_RD,
        M_WR,
        M_DRAIN
    } mode_t;

    // Tags that close a command stream
    function automatic logic is_end_tag(input logic [2:0] tag);
        return (tag == TAG_LAST) || (tag == TAG_SINGLE);
    endfunction

endpackage

// File: rtl/nmac_bus_master.sv
// rtl/nmac_bus_master.sv - single-access register bus master with ack timeout
//
// Purpose: runs one read or write access per start pulse, holding the strobe,
// address and write data stable until bus_ack or TIMEOUT strobe cycles, and
// keeps a saturating count of timed-out accesses.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i, is_write_i   launch an access (ignored while one is in flight)
//   addr_i, wdata_i       access address and write data, captured on start_i
//   done_o                access completes this cycle (ack or timeout)
//   rdata_o               bus read data, meaningful with done_o and !timed_out_o
//   timed_out_o           completion was a timeout
//   bus_*                 register bus
//   timeout_cnt_o         saturating timed-out access count

module nmac_bus_master #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        is_write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        timed_out_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic        bus_rd_o,
    output logic        bus_wr_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic [15:0] timeout_cnt_o
);

    localparam logic [7:0] LAST_CNT = TIMEOUT - 8'd1;

    logic        active_q;
    logic        write_q;
    logic [7:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [15:0] tcnt_q;
    logic [15:0] tcnt_d;
    logic        expire;

    // cnt_q counts strobe cycles already spent, so the strobe is high for
    // exactly TIMEOUT cycles when no ack arrives. An ack in the final cycle wins.
    assign expire      = active_q && (cnt_q == LAST_CNT);
    assign done_o      = active_q && (bus_ack_i || expire);
    assign timed_out_o = expire && !bus_ack_i;
    assign rdata_o     = bus_rdata_i;

    assign tcnt_d = (timed_out_o && (tcnt_q != 16'hFFFF)) ? tcnt_q + 16'd1 : tcnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
            write_q  <= 1'b0;
            cnt_q    <= 8'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            tcnt_q   <= 16'd0;
        end else begin
            tcnt_q <= tcnt_d;
            if (start_i && !active_q) begin
                active_q <= 1'b1;
                write_q  <= is_write_i;
                cnt_q    <= 8'd0;
                addr_q   <= addr_i;
                wdata_q  <= wdata_i;
            end else if (done_o) begin
                active_q <= 1'b0;
            end else if (active_q) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    // Strobes derive from reset-cleared flops, so they drop as soon as reset rises
    assign bus_rd_o      = active_q && !write_q;
    assign bus_wr_o      = active_q && write_q;
    assign bus_addr_o    = addr_q;
    assign bus_wdata_o   = wdata_q;
    assign timeout_cnt_o = tcnt_q;

endmodule

// File: rtl/nmac_cmd_exec.sv
// rtl/nmac_cmd_exec.sv - NMAC command executor between command FIFOs and register bus
//
// Purpose: pops tagged command words and their sequence records, executes
// establish/read/write commands one at a time on the register bus and pushes
// tagged response words plus a response sequence record.
// Ports:
//   clk, reset                          clock, asynchronous active-high reset
//   command_q/_empty/_rdreq             command FIFO (q valid the cycle after rdreq)
//   sequence_q/_empty/_rdreq            sequence FIFO ([16] valid, [15:0] number)
//   bus_addr/_wdata/_rd/_wr/_rdata/_ack register bus
//   resp_data/_wr, resp_usedw           response word FIFO
//   resp_seq/_wr                        response sequence FIFO
//   timeout_cnt                         saturating count of timed-out accesses

module nmac_cmd_exec
    import nmac_pkg::*;
#(
    parameter logic [7:0]  TIMEOUT    = 8'd255,
    parameter logic [7:0]  RESP_AFULL = 8'd240,
    parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [34:0] command_q,
    input  logic        command_empty,
    output logic        command_rdreq,
    input  logic [16:0] sequence_q,
    input  logic        sequence_empty,
    output logic        sequence_rdreq,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_rd,
    output logic        bus_wr,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [34:0] resp_data,
    output logic        resp_wr,
    input  logic [7:0]  resp_usedw,
    output logic [16:0] resp_seq,
    output logic        resp_seq_wr,
    output logic [15:0] timeout_cnt
);

    state_t      state_q;
    mode_t       mode_q;
    logic        wr_data_q;   // next write body word is data, not address
    logic        last_q;      // access in flight came from a tag-010 word
    logic [31:0] addr_q;      // write address awaiting its data word
    logic        cmd_rdreq_q;
    logic        seq_rdreq_q;
    logic        resp_wr_q;
    logic        resp_seq_wr_q;
    logic [34:0] resp_data_q;
    logic [16:0] resp_seq_q;

    logic [2:0]  cmd_tag;
    logic [7:0]  cmd_op;
    logic [31:0] cmd_word;
    logic        op_known;
    logic        can_start;

    logic        bm_start;
    logic        bm_write;
    logic [31:0] bm_addr;
    logic        bm_done;
    logic [31:0] bm_rdata;
    logic        bm_timed_out;
    logic [31:0] rd_result;

    assign cmd_tag   = command_q[34:32];
    assign cmd_word  = command_q[31:0];
    assign cmd_op    = command_q[31:24];
    assign op_known  = (cmd_op == OP_EST) || (cmd_op == OP_RD) || (cmd_op == OP_WR);
    assign can_start = !command_empty && !sequence_empty && (resp_usedw <= RESP_AFULL);

    // The access launches straight from the word on command_q so the strobe
    // rises the cycle after the word becomes valid. A write uses the address
    // captured from the preceding word.
    always_comb begin
        bm_start = 1'b0;
        if (state_q == S_WORD) begin
            bm_start = (mode_q == M_RD) || ((mode_q == M_WR) && wr_data_q);
        end
    end
    assign bm_write  = (mode_q == M_WR);
    assign bm_addr   = bm_write ? addr_q : cmd_word;
    assign rd_result = bm_timed_out ? ERR_DATA : bm_rdata;

    nmac_bus_master #(
        .TIMEOUT(TIMEOUT)
    ) u_bus_master (
        .clk_i        (clk),
        .rst_i        (reset),
        .start_i      (bm_start),
        .is_write_i   (bm_write),
        .addr_i       (bm_addr),
        .wdata_i      (cmd_word),
        .done_o       (bm_done),
        .rdata_o      (bm_rdata),
        .timed_out_o  (bm_timed_out),
        .bus_addr_o   (bus_addr),
        .bus_wdata_o  (bus_wdata),
        .bus_rd_o     (bus_rd),
        .bus_wr_o     (bus_wr),
        .bus_rdata_i  (bus_rdata),
        .bus_ack_i    (bus_ack),
        .timeout_cnt_o(timeout_cnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            mode_q        <= M_RD;
            wr_data_q     <= 1'b0;
            last_q        <= 1'b0;
            addr_q        <= 32'd0;
            cmd_rdreq_q   <= 1'b0;
            seq_rdreq_q   <= 1'b0;
            resp_wr_q     <= 1'b0;
            resp_seq_wr_q <= 1'b0;
            resp_data_q   <= 35'd0;
            resp_seq_q    <= 17'd0;
        end else begin
            // All FIFO strobes are single-cycle pulses
            cmd_rdreq_q   <= 1'b0;
            seq_rdreq_q   <= 1'b0;
            resp_wr_q     <= 1'b0;
            resp_seq_wr_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (can_start) begin
                        cmd_rdreq_q <= 1'b1;
                        seq_rdreq_q <= 1'b1;
                        state_q     <= S_HWAIT;
                    end
                end

                S_HWAIT: state_q <= S_HDR;

                S_HDR: begin
                    if (!sequence_q[16] || !op_known) begin
                        mode_q  <= M_DRAIN;
                        state_q <= (cmd_tag == TAG_SINGLE) ? S_IDLE : S_FETCH;
                    end else begin
                        resp_wr_q   <= 1'b1;
                        resp_data_q <= {((cmd_tag == TAG_SINGLE) || (cmd_op == OP_WR)) ?
                                        TAG_SINGLE : TAG_FIRST, cmd_word};
                        resp_seq_q  <= {1'b1, sequence_q[15:0]};
                        wr_data_q   <= 1'b0;
                        if (cmd_tag == TAG_SINGLE) begin
                            resp_seq_wr_q <= 1'b1;
                            state_q       <= S_IDLE;
                        end else if (cmd_op == OP_EST) begin
                            mode_q  <= M_DRAIN;
                            state_q <= S_FETCH;
                        end else begin
                            mode_q  <= (cmd_op == OP_WR) ? M_WR : M_RD;
                            state_q <= S_FETCH;
                        end
                    end
                end

                S_FETCH: begin
                    if (!command_empty) begin
                        cmd_rdreq_q <= 1'b1;
                        state_q     <= S_FWAIT;
                    end
                end

                S_FWAIT: state_q <= S_WORD;

                S_WORD: begin
                    case (mode_q)
                        M_RD: begin
                            last_q  <= (cmd_tag == TAG_LAST);
                            state_q <= S_BUS;
                        end
                        M_WR: begin
                            if (wr_data_q) begin
                                last_q    <= (cmd_tag == TAG_LAST);
                                wr_data_q <= 1'b0;
                                state_q   <= S_BUS;
                            end else begin
                                addr_q <= cmd_word;
                                if (cmd_tag == TAG_LAST) begin
                                    // Stream ended on an address: the access is dropped
                                    resp_seq_wr_q <= 1'b1;
                                    state_q       <= S_IDLE;
                                end else begin
                                    wr_data_q <= 1'b1;
                                    state_q   <= S_FETCH;
                                end
                            end
                        end
                        default: begin
                            state_q <= is_end_tag(cmd_tag) ? S_IDLE : S_FETCH;
                        end
                    endcase
                end

                S_BUS: begin
                    if (bm_done) begin
                        if (mode_q == M_RD) begin
                            resp_wr_q   <= 1'b1;
                            resp_data_q <= {last_q ? TAG_LAST : TAG_MID, rd_result};
                            state_q     <= last_q ? S_SEQ : S_FETCH;
                        end else if (last_q) begin
                            resp_seq_wr_q <= 1'b1;
                            state_q       <= S_IDLE;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end
                end

                S_SEQ: begin
                    resp_seq_wr_q <= 1'b1;
                    state_q       <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign command_rdreq  = cmd_rdreq_q;
    assign sequence_rdreq = seq_rdreq_q;
    assign resp_wr        = resp_wr_q;
    assign resp_data      = resp_data_q;
    assign resp_seq_wr    = resp_seq_wr_q;
    assign resp_seq       = resp_seq_q;

endmodule

// File: tb/tb_nmac_cmd_exec.sv
// tb/tb_nmac_cmd_exec.sv - self-checking bench for nmac_cmd_exec

module tb_nmac_cmd_exec;

    typedef struct {
        logic [34:0] data;
        int          lat;
    } resp_t;

    typedef struct {
        logic [16:0] val;
        int          gap;
    } seq_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    logic        clk;
    logic        reset;
    logic [34:0] command_q;
    logic        command_empty;
    logic        command_rdreq;
    logic [16:0] sequence_q;
    logic        sequence_empty;
    logic        sequence_rdreq;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_rd;
    logic        bus_wr;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic [34:0] resp_data;
    logic        resp_wr;
    logic [7:0]  resp_usedw;
    logic [16:0] resp_seq;
    logic        resp_seq_wr;
    logic [15:0] timeout_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_pop_cyc = 0;
    int last_resp_cyc = 0;
    int cmd_pops = 0;
    int seq_pops = 0;
    int strobe_starts = 0;
    int strobe_age = 0;
    int wr_cycles = 0;
    int ack_lat = 0;
    logic ack_never = 1'b0;

    logic [34:0] cmd_fifo[$];
    logic [16:0] seq_fifo[$];
    logic [31:0] rdata_q[$];
    resp_t       exp_resp[$];
    seq_t        exp_seq[$];
    bus_t        exp_bus[$];
    resp_t       er;
    seq_t        es;
    bus_t        eb;

    nmac_cmd_exec dut (
        .clk           (clk),
        .reset         (reset),
        .command_q     (command_q),
        .command_empty (command_empty),
        .command_rdreq (command_rdreq),
        .sequence_q    (sequence_q),
        .sequence_empty(sequence_empty),
        .sequence_rdreq(sequence_rdreq),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_rd        (bus_rd),
        .bus_wr        (bus_wr),
        .bus_rdata     (bus_rdata),
        .bus_ack       (bus_ack),
        .resp_data     (resp_data),
        .resp_wr       (resp_wr),
        .resp_usedw    (resp_usedw),
        .resp_seq      (resp_seq),
        .resp_seq_wr   (resp_seq_wr),
        .timeout_cnt   (timeout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Normal-mode FIFO models: q updates the cycle after rdreq
    always @(posedge clk) begin
        if (command_rdreq) begin
            check("cmd_pop_nonempty", 64'(cmd_fifo.size() != 0), 64'd1);
            if (cmd_fifo.size() != 0) command_q <= cmd_fifo.pop_front();
            cmd_pops++;
        end
        if (sequence_rdreq) begin
            check("seq_pop_nonempty", 64'(seq_fifo.size() != 0), 64'd1);
            if (seq_fifo.size() != 0) sequence_q <= seq_fifo.pop_front();
            seq_pops++;
        end
        #1;
        command_empty  = (cmd_fifo.size() == 0);
        sequence_empty = (seq_fifo.size() == 0);
    end

    // Bus responder: acks ack_lat strobe cycles after the strobe rises
    always @(negedge clk) begin
        if (bus_wr) wr_cycles++;
        if ((bus_rd || bus_wr) && !bus_ack) begin
            if (strobe_age == 0) begin
                strobe_starts++;
                check("bus_pending", 64'(exp_bus.size() != 0), 64'd1);
                if (exp_bus.size() != 0) begin
                    eb = exp_bus.pop_front();
                    check("bus_we_addr", {31'd0, bus_wr, bus_addr}, {31'd0, eb.we, eb.addr});
                    if (eb.we) check("bus_wdata", 64'(bus_wdata), 64'(eb.wdata));
                end
            end
            if (!ack_never && strobe_age == ack_lat) begin
                bus_ack   = 1'b1;
                bus_rdata = (rdata_q.size() != 0) ? rdata_q.pop_front() : 32'd0;
            end
            strobe_age++;
        end else begin
            bus_ack    = 1'b0;
            strobe_age = 0;
        end
    end

    // Response scoreboard
    always @(negedge clk) begin
        if (command_rdreq) last_pop_cyc = cyc;
        if (resp_wr) begin
            check("resp_pending", 64'(exp_resp.size() != 0), 64'd1);
            if (exp_resp.size() != 0) begin
                er = exp_resp.pop_front();
                check("resp_data", 64'(resp_data), 64'(er.data));
                check("resp_latency", 64'(cyc - last_pop_cyc), 64'(er.lat));
            end
            last_resp_cyc = cyc;
        end
        if (resp_seq_wr) begin
            check("seq_pending", 64'(exp_seq.size() != 0), 64'd1);
            if (exp_seq.size() != 0) begin
                es = exp_seq.pop_front();
                check("resp_seq", 64'(resp_seq), 64'(es.val));
                if (es.gap >= 0) check("seq_gap", 64'(cyc - last_resp_cyc), 64'(es.gap));
            end
        end
    end

    task automatic push_word(input logic [2:0] tag, input logic [31:0] w);
        cmd_fifo.push_back({tag, w});
        command_empty = 1'b0;
    endtask

    task automatic push_seq(input logic [16:0] s);
        seq_fifo.push_back(s);
        sequence_empty = 1'b0;
    endtask

    task automatic exp_r(input logic [2:0] tag, input logic [31:0] w, input int lat);
        resp_t r;
        r.data = {tag, w};
        r.lat  = lat;
        exp_resp.push_back(r);
    endtask

    task automatic exp_s(input logic [16:0] v, input int gap);
        seq_t s;
        s.val = v;
        s.gap = gap;
        exp_seq.push_back(s);
    endtask

    task automatic exp_b(input logic we, input logic [31:0] a, input logic [31:0] d);
        bus_t b;
        b.we    = we;
        b.addr  = a;
        b.wdata = d;
        exp_bus.push_back(b);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_resp.size() != 0 || exp_seq.size() != 0 || exp_bus.size() != 0 ||
                cmd_fifo.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_complete"},
              64'(exp_resp.size() == 0 && exp_seq.size() == 0 && exp_bus.size() == 0 &&
                  cmd_fifo.size() == 0), 64'd1);
        repeat (8) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string p);
        check({p, "_strobes"}, 64'({command_rdreq, sequence_rdreq, bus_rd, bus_wr, resp_wr, resp_seq_wr}), 64'd0);
        check({p, "_bus"}, {bus_addr, bus_wdata}, 64'd0);
        check({p, "_resp_data"}, 64'(resp_data), 64'd0);
        check({p, "_resp_seq"}, 64'(resp_seq), 64'd0);
        check({p, "_timeout_cnt"}, 64'(timeout_cnt), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int p0;
        int s0;
        reset          = 1'b1;
        command_q      = 35'd0;
        command_empty  = 1'b1;
        sequence_q     = 17'd0;
        sequence_empty = 1'b1;
        bus_rdata      = 32'd0;
        bus_ack        = 1'b0;
        resp_usedw     = 8'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset0");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Establish, single word
        s0 = strobe_starts;
        push_seq(17'h10012);
        push_word(3'b100, 32'h0100_0000);
        exp_r(3'b100, 32'h0100_0000, 2);
        exp_s(17'h10012, 0);
        drain("establish", 50);
        check("establish_no_bus", 64'(strobe_starts - s0), 64'd0);

        // Read of two addresses, ack 2 cycles after strobe
        ack_lat = 2;
        push_seq(17'h10034);
        push_word(3'b001, 32'h0300_0000);
        push_word(3'b011, 32'h0000_0010);
        push_word(3'b010, 32'h0000_0014);
        rdata_q.push_back(32'hA5A5_A5A5);
        rdata_q.push_back(32'h5A5A_5A5A);
        exp_b(1'b0, 32'h10, 32'h0);
        exp_b(1'b0, 32'h14, 32'h0);
        exp_r(3'b001, 32'h0300_0000, 2);
        exp_r(3'b011, 32'hA5A5_A5A5, 5);
        exp_r(3'b010, 32'h5A5A_5A5A, 5);
        exp_s(17'h10034, 1);
        drain("read2", 100);

        // Write pair, bus never acks
        ack_never = 1'b1;
        wr_cycles = 0;
        push_seq(17'h10056);
        push_word(3'b001, 32'h0400_0000);
        push_word(3'b011, 32'h0000_0020);
        push_word(3'b010, 32'hCAFE_F00D);
        exp_b(1'b1, 32'h20, 32'hCAFE_F00D);
        exp_r(3'b100, 32'h0400_0000, 2);
        exp_s(17'h10056, -1);
        drain("write_timeout", 400);
        check("write_strobe_cycles", 64'(wr_cycles), 64'd255);
        check("timeout_cnt_1", 64'(timeout_cnt), 64'd1);
        ack_never = 1'b0;

        // Read with invalid sequence record: drained silently
        p0 = cmd_pops;
        s0 = strobe_starts;
        push_seq(17'h00078);
        push_word(3'b001, 32'h0300_0000);
        push_word(3'b011, 32'h0000_0050);
        push_word(3'b011, 32'h0000_0054);
        push_word(3'b010, 32'h0000_0058);
        drain("invalid_seq", 60);
        check("invalid_seq_pops", 64'(cmd_pops - p0), 64'd4);
        check("invalid_seq_no_bus", 64'(strobe_starts - s0), 64'd0);

        // Response FIFO above threshold holds off the next command
        resp_usedw = 8'd241;
        p0 = cmd_pops;
        push_seq(17'h1009A);
        push_word(3'b100, 32'h0100_00AA);
        exp_r(3'b100, 32'h0100_00AA, 2);
        exp_s(17'h1009A, 0);
        repeat (20) @(negedge clk);
        check("afull_no_pop", 64'(cmd_pops - p0), 64'd0);
        resp_usedw = 8'd240;
        drain("afull_release", 50);
        check("afull_release_pops", 64'(cmd_pops - p0), 64'd1);
        resp_usedw = 8'd0;

        // Reset while bus_rd is held
        ack_never = 1'b1;
        push_seq(17'h100BC);
        push_word(3'b001, 32'h0300_0000);
        push_word(3'b010, 32'h0000_0040);
        exp_r(3'b001, 32'h0300_0000, 2);
        exp_b(1'b0, 32'h40, 32'h0);
        n = 0;
        while (!bus_rd && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reset_bus_rd_seen", 64'(bus_rd), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("reset_bus_rd_drop", 64'(bus_rd), 64'd0);
        check_reset_outputs("reset_mid");
        exp_resp.delete();
        exp_seq.delete();
        exp_bus.delete();
        cmd_fifo.delete();
        seq_fifo.delete();
        command_empty  = 1'b1;
        sequence_empty = 1'b1;
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        ack_never = 1'b0;
        repeat (2) @(negedge clk);

        // Read after reset with single-cycle ack
        ack_lat = 0;
        push_seq(17'h100DE);
        push_word(3'b001, 32'h0300_0000);
        push_word(3'b010, 32'h0000_0044);
        rdata_q.push_back(32'h1234_5678);
        exp_b(1'b0, 32'h44, 32'h0);
        exp_r(3'b001, 32'h0300_0000, 2);
        exp_r(3'b010, 32'h1234_5678, 3);
        exp_s(17'h100DE, 1);
        drain("read_after_reset", 60);

        // Write stream of two pairs ending on a lone address word
        ack_lat = 1;
        push_seq(17'h100F0);
        push_word(3'b001, 32'h0400_0000);
        push_word(3'b011, 32'h0000_0030);
        push_word(3'b011, 32'h1111_1111);
        push_word(3'b011, 32'h0000_0034);
        push_word(3'b011, 32'h2222_2222);
        push_word(3'b010, 32'h0000_0038);
        exp_b(1'b1, 32'h30, 32'h1111_1111);
        exp_b(1'b1, 32'h34, 32'h2222_2222);
        exp_r(3'b100, 32'h0400_0000, 2);
        exp_s(17'h100F0, -1);
        drain("write_dropped_tail", 120);
        check("timeout_cnt_after_reset", 64'(timeout_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
